// File: rtl/shift_rows_stage_pkg.sv
// Shared helpers for the ShiftRows stage: row offsets, byte indexing, legal block
// widths and the handshake state encoding.
package shift_rows_stage_pkg;

  // Bit n is set when NB = n columns is supported.
  localparam logic [8:0] NB_LEGAL = 9'b1_0101_0000;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_state_e;

  function automatic bit nb_is_legal(input int nb);
    if (nb < 0 || nb > 8) return 1'b0;
    return NB_LEGAL[nb[3:0]];
  endfunction

  // Rijndael offsets: 0,1,2,3 for Nb = 4/6 and 0,1,3,4 for Nb = 8.
  function automatic int row_offset(input int nb, input int r);
    if (r == 0) return 0;
    if (nb == 8 && r > 1) return r + 1;
    return r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_stage_rows_permute.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
// Pure wiring plus one 2:1 mux per byte; inv selects the direction per beat.
module rows_permute
  import shift_rows_stage_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:32*NB-1] in,
  input  logic             inv,
  output logic [0:32*NB-1] out
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("rows_permute: NB must be 4, 6 or 8");
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S       = row_offset(NB, r);
      localparam int SRC_FWD = (c + S) % NB;
      localparam int SRC_INV = (c - S + NB) % NB;

      assign out[8*byte_idx(r, c) +: 8] = inv ? in[8*byte_idx(r, SRC_INV) +: 8]
                                              : in[8*byte_idx(r, SRC_FWD) +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stage.sv
// Registered ShiftRows / InvShiftRows pipeline stage with a two-entry skid buffer.
// Data is permuted before capture, so both registers hold already-shifted state.
module shift_rows_stage
  import shift_rows_stage_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:32*NB-1] in_data,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:32*NB-1] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_stage: TAG_W must be at least 1");
  end

  stage_state_e     state;
  logic [0:32*NB-1] shifted;
  logic [0:32*NB-1] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  rows_permute #(.NB(NB)) u_permute (
    .in  (in_data),
    .inv (in_inv),
    .out (shifted)
  );

  // out_data/out_tag are the main register; in_ready is registered so that
  // out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data  <= shifted;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= shifted;
            out_tag  <= in_tag;
          end else if (in_xfer) begin
            skid_data <= shifted;
            skid_tag  <= in_tag;
            in_ready  <= 1'b0;
            state     <= ST_FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
            state    <= ST_ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Self-checking bench for shift_rows_stage: NB=4 handshake instance with a queue
// scoreboard, plus NB=6 and NB=8 instances checked beat by beat.
module tb_shift_rows_stage;

  typedef logic [7:0] st_t [32];
  typedef struct {
    logic [0:127] data;
    logic [3:0]   tag;
  } beat_t;

  localparam logic [0:127] KAT_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] KAT_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [0:127] in_data, out_data;
  logic [3:0]   in_tag, out_tag;

  logic         v6, rdy6, inv6, ov6;
  logic [0:191] d6, q6;
  logic [3:0]   t6;
  logic         v8, rdy8, inv8, ov8;
  logic [0:255] d8, q8;
  logic [3:0]   t8;
  logic         one = 1'b1;
  logic [3:0]   tag_z = 4'h0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int mode = 0;
  int bp_base = 0;
  int n_out = 0;
  logic bp_rdy3 = 1'bx;
  logic bp_rdy4 = 1'bx;
  logic rst_at_edge = 1'b1;
  beat_t q[$];
  logic [3:0] seen[$];

  shift_rows_stage #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag));

  shift_rows_stage #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6), .in_data(d6),
    .in_inv(inv6), .in_tag(tag_z), .out_valid(ov6), .out_ready(one),
    .out_data(q6), .out_tag(t6));

  shift_rows_stage #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_inv(inv8), .in_tag(tag_z), .out_valid(ov8), .out_ready(one),
    .out_data(q8), .out_tag(t8));

  // Reference: out(r,c) = in(r, c +/- s_r mod nb), on a flat array of 32 bytes.
  function automatic st_t shift_model(input st_t s, input int nb, input bit inv);
    int   off[4];
    int   src;
    st_t  o;
    off[0] = 0;
    off[1] = 1;
    off[2] = (nb == 8) ? 3 : 2;
    off[3] = (nb == 8) ? 4 : 3;
    for (int k = 0; k < 32; k++) o[k] = 8'h00;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        o[4*c + r] = s[4*src + r];
      end
    end
    return o;
  endfunction

  function automatic logic [0:255] model_vec(input logic [0:255] v, input int nb, input bit inv);
    st_t s, o;
    logic [0:255] r;
    for (int k = 0; k < 32; k++) s[k] = v[8*k +: 8];
    o = shift_model(s, nb, inv);
    for (int k = 0; k < 32; k++) r[8*k +: 8] = o[k];
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  // out_ready pattern per test phase: 0 high, 1 random, 2 scripted stall, 3 low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      cycle++;
      #2;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = !((cycle - bp_base) >= 3 && (cycle - bp_base) <= 6);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard for the NB=4 instance, sampled mid-cycle.
  logic         hold_prev = 1'b0;
  logic [0:127] prev_data;
  logic [3:0]   prev_tag;
  always @(negedge clk) begin
    beat_t        e;
    logic [0:255] m;
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      check(in_ready === ((q.size() < 2) && !rst_at_edge), "in_ready", in_ready,
            (q.size() < 2) && !rst_at_edge);
      check(out_valid === (q.size() != 0), "out_valid", out_valid, q.size() != 0);
      if (hold_prev) begin
        check(out_data === prev_data && out_tag === prev_tag, "stall_stable",
              {out_tag, out_data}, {prev_tag, prev_data});
      end
      if (out_valid && q.size() != 0) begin
        check(out_data === q[0].data, "out_data", out_data, q[0].data);
        check(out_tag === q[0].tag, "out_tag", out_tag, q[0].tag);
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      if (out_valid && out_ready && q.size() != 0) begin
        seen.push_back(out_tag);
        void'(q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        m = model_vec({in_data, 128'b0}, 4, in_inv);
        e.data = m[0:127];
        e.tag  = in_tag;
        q.push_back(e);
      end
      if (mode == 2 && cycle - bp_base == 3) bp_rdy3 = in_ready;
      if (mode == 2 && cycle - bp_base == 4) bp_rdy4 = in_ready;
    end
  end

  // Presents a beat (called at posedge+1) and returns just after the edge that took it.
  task automatic send(input logic [0:127] d, input bit inv, input logic [3:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        check(1'b0, "send_timeout", 0, 1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    mode = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(q.size() == 0, "drain", q.size(), 0);
  endtask

  task automatic beat8(input logic [0:255] d, input bit inv);
    logic [0:255] m;
    check(rdy8 === 1'b1, "nb8_in_ready", rdy8, 1);
    v8 = 1'b1; d8 = d; inv8 = inv;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    m = model_vec(d, 8, inv);
    check(ov8 === 1'b1, "nb8_valid", ov8, 1);
    check(q8 === m, "nb8_data", q8, m);
  endtask

  task automatic beat6(input logic [0:191] d, input bit inv);
    logic [0:255] m;
    check(rdy6 === 1'b1, "nb6_in_ready", rdy6, 1);
    v6 = 1'b1; d6 = d; inv6 = inv;
    @(posedge clk);
    #1;
    v6 = 1'b0;
    m = model_vec({d, 64'b0}, 6, inv);
    check(ov6 === 1'b1, "nb6_valid", ov6, 1);
    check(q6 === m[0:191], "nb6_data", q6, m[0:191]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [0:127] x, y;
    logic [0:255] m, seq8;
    logic [0:191] seq6;
    int           base;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_tag = '0;
    v6 = 1'b0; d6 = '0; inv6 = 1'b0; v8 = 1'b0; d8 = '0; inv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
    check(out_data === '0, "rst_out_data", out_data, 0);
    check(out_tag === '0, "rst_out_tag", out_tag, 0);
    check(in_ready === 1'b0, "rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check(in_ready === 1'b1, "rst_release_in_ready", in_ready, 1);

    // Known-answer vector; also pins the model.
    m = model_vec({KAT_IN, 128'b0}, 4, 1'b0);
    check(m[0:127] === KAT_OUT, "model_kat", m[0:127], KAT_OUT);
    send(KAT_IN, 1'b0, 4'h1);
    in_valid = 1'b0;
    check(out_valid === 1'b1, "kat_fwd_valid", out_valid, 1);
    check(out_data === KAT_OUT, "kat_fwd_data", out_data, KAT_OUT);
    y = out_data;
    send(y, 1'b1, 4'h2);
    in_valid = 1'b0;
    check(out_data === KAT_IN, "kat_inv_data", out_data, KAT_IN);
    drain();

    // NB=8 and NB=6 with byte i = i.
    for (int k = 0; k < 32; k++) seq8[8*k +: 8] = 8'(k);
    for (int k = 0; k < 24; k++) seq6[8*k +: 8] = 8'(k);
    beat8(seq8, 1'b0);
    check(q8[8 +: 8] === 8'h05, "nb8_r1c0", q8[8 +: 8], 8'h05);
    check(q8[16 +: 8] === 8'h0e, "nb8_r2c0", q8[16 +: 8], 8'h0e);
    check(q8[24 +: 8] === 8'h13, "nb8_r3c0", q8[24 +: 8], 8'h13);
    beat6(seq6, 1'b0);
    check(q6[8 +: 8] === 8'h05, "nb6_r1c0", q6[8 +: 8], 8'h05);
    check(q6[16 +: 8] === 8'h0a, "nb6_r2c0", q6[16 +: 8], 8'h0a);
    check(q6[24 +: 8] === 8'h0f, "nb6_r3c0", q6[24 +: 8], 8'h0f);
    for (int i = 0; i < 20; i++) begin
      beat8({rand128(), rand128()}, 1'($urandom_range(0, 1)));
      beat6({rand128(), 64'({$urandom, $urandom})}, 1'($urandom_range(0, 1)));
    end

    // Forward then inverse through the DUT is the identity.
    for (int i = 0; i < 1000; i++) begin
      x = rand128();
      send(x, 1'b0, 4'(i));
      in_valid = 1'b0;
      y = out_data;
      send(y, 1'b1, 4'(i + 1));
      in_valid = 1'b0;
      check(out_data === x, "roundtrip", out_data, x);
    end
    drain();

    // Random traffic with random backpressure.
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand128(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    drain();

    // Scripted stall: out_ready low on relative cycles 3..6.
    seen.delete();
    bp_base = cycle;
    mode = 2;
    for (int t = 0; t < 8; t++) send(rand128(), 1'(t % 2), 4'(t));
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drain();
    check(bp_rdy3 === 1'b1, "bp_in_ready_c3", bp_rdy3, 1);
    check(bp_rdy4 === 1'b0, "bp_in_ready_c4", bp_rdy4, 0);
    check(seen.size() == 8, "bp_count", seen.size(), 8);
    for (int t = 0; t < 8 && t < seen.size(); t++)
      check(seen[t] === 4'(t), "bp_order", seen[t], t);

    // Alternating modes at full rate: eight outputs in eight consecutive cycles.
    base = n_out;
    for (int t = 0; t < 8; t++) send(rand128(), 1'(t % 2), 4'(t));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check(n_out - base == 8, "alt_throughput", n_out - base, 8);
    drain();

    // Reset while FULL discards both entries.
    mode = 3;
    send(rand128(), 1'b0, 4'hA);
    send(rand128(), 1'b1, 4'hB);
    in_valid = 1'b0;
    check(in_ready === 1'b0, "full_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(out_valid === 1'b0, "rst_mid_valid", out_valid, 0);
    check(out_tag === 4'h0, "rst_mid_tag", out_tag, 0);
    mode = 0;
    @(posedge clk);
    #1;
    check(in_ready === 1'b1, "rst_mid_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check(out_valid === 1'b0, "rst_no_stale", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
